// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace packer.
// Optional build macro: COMMIT_TRACE_FILTER_X0_EN (drop rd==0 commits).
package commit_trace_pkg;

   localparam logic [7:0] TRACE_MAGIC = 8'hA5;

   typedef struct packed {
      logic [15:0] seq;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] data;
   } commit_rec_t;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      PC,
      DATA
   } pack_state_e;

   function automatic logic [31:0] hdr_word(input commit_rec_t r);
      return {TRACE_MAGIC, 3'b000, r.rd, r.seq};
   endfunction

endpackage

// File: rtl/commit_trace_fifo.sv
// Record FIFO between the commit port and the packet FSM.
// A push while full is taken only if a pop frees the slot at the same edge.
module commit_trace_fifo
   import commit_trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  commit_rec_t              wdata,
   input  logic                     pop,
   output commit_rec_t              head,
   output commit_rec_t              next,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   commit_rec_t mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic do_push;
   logic do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];
   assign next    = mem[rd_ptr + AW'(1)];

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      level <= level + 1'b1;
         else if (do_pop && !do_push) level <= level - 1'b1;
      end
   end

   // storage array, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/commit_trace_packer.sv
// Packs retired register writes into 3-word trace packets.
// Optional build macro: COMMIT_TRACE_FILTER_X0_EN (drop rd==0 commits).
module commit_trace_packer
   import commit_trace_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   commit_valid,
   input  logic [31:0]            commit_pc,
   input  logic [4:0]             commit_rd,
   input  logic [31:0]            commit_data,
   output logic                   trace_valid,
   input  logic                   trace_ready,
   output logic [31:0]            trace_word,
   output logic                   trace_last,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [CNT_W-1:0]       overflow_cnt
);

   localparam int LW = $clog2(DEPTH) + 1;

   logic [15:0] seq;
   commit_rec_t rec;
   commit_rec_t head;
   commit_rec_t nxt;
   pack_state_e state;
   logic keep;
   logic full;
   logic empty;
   logic push;
   logic pop;
   logic drop;

   assign rec = '{seq: seq, rd: commit_rd, pc: commit_pc, data: commit_data};

`ifdef COMMIT_TRACE_FILTER_X0_EN
   assign keep = commit_valid && (commit_rd != 5'd0);
`else
   assign keep = commit_valid;
`endif

   assign pop  = (state == DATA) && trace_valid && trace_ready;
   assign push = keep && (!full || pop);
   assign drop = keep && full && !pop;

   commit_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wdata   (rec),
      .pop     (pop),
      .head    (head),
      .next    (nxt),
      .full    (full),
      .empty   (empty),
      .level   (fifo_level)
   );

   // sequence number advances on every sampled commit, kept or not
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          seq <= '0;
      else if (commit_valid) seq <= seq + 16'd1;
   end

   // saturating count of records lost to a full FIFO
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        overflow_cnt <= '0;
      else if (drop && overflow_cnt != '1) overflow_cnt <= overflow_cnt + 1'b1;
   end

   // packet FSM with registered stream outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         trace_valid <= 1'b0;
         trace_word  <= '0;
         trace_last  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (!empty) begin
               state       <= HDR;
               trace_valid <= 1'b1;
               trace_word  <= hdr_word(head);
               trace_last  <= 1'b0;
            end
            HDR: if (trace_ready) begin
               state      <= PC;
               trace_word <= head.pc;
            end
            PC: if (trace_ready) begin
               state      <= DATA;
               trace_word <= head.data;
               trace_last <= 1'b1;
            end
            DATA: if (trace_ready) begin
               trace_last <= 1'b0;
               if (fifo_level > LW'(1)) begin
                  state      <= HDR;
                  trace_word <= hdr_word(nxt);
               end else if (push) begin
                  state      <= HDR;
                  trace_word <= hdr_word(rec);
               end else begin
                  state       <= IDLE;
                  trace_valid <= 1'b0;
                  trace_word  <= '0;
               end
            end
         endcase
      end
   end

endmodule
